// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared RV32I definitions for the decode slice:
//     - base opcode values (instr[6:0]) for every RV32I major opcode
//     - immediate/instruction format encoding used between imm_gen and
//       decode_stage
//     - helper predicates on opcodes
// -----------------------------------------------------------------------------
package riscv_pkg;

    // Major opcodes of the RV32I base set. Every legal opcode has bits [1:0]
    // equal to 2'b11, so an exact match against this list also rejects
    // compressed-looking encodings.
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Instruction format. FMT_NONE marks an opcode outside the RV32I set.
    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    // Opcodes whose instr[30] carries the funct7[5] alternate-operation bit
    // (SUB/SRA and SRAI).
    function automatic logic has_funct7b5(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_OP_IMM);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
//   Purely combinational RV32I format classifier and immediate generator.
//   Ports:
//     instr  in   INSTR_WIDTH  raw instruction
//     imm    out  INSTR_WIDTH  sign-extended immediate (0 for R format and
//                              for unrecognised opcodes)
//     fmt    out  fmt_e        instruction format, FMT_NONE when the opcode is
//                              not part of RV32I
//   The bit fields below assume the 32-bit RV32I encoding; INSTR_WIDTH only
//   sets the width of the extended immediate and must be at least 32.
// -----------------------------------------------------------------------------
module imm_gen
    import riscv_pkg::*;
#(
    parameter int INSTR_WIDTH = 32
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic [INSTR_WIDTH-1:0] imm,
    output fmt_e                   fmt
);

    // Format selection. MISC_MEM (FENCE) and SYSTEM are treated as I form so
    // their fields pass through uniformly.
    always_comb begin
        fmt = FMT_NONE;
        case (instr[6:0])
            OPC_OP:       fmt = FMT_R;
            OPC_OP_IMM,
            OPC_LOAD,
            OPC_JALR,
            OPC_MISC_MEM,
            OPC_SYSTEM:   fmt = FMT_I;
            OPC_STORE:    fmt = FMT_S;
            OPC_BRANCH:   fmt = FMT_B;
            OPC_LUI,
            OPC_AUIPC:    fmt = FMT_U;
            OPC_JAL:      fmt = FMT_J;
            default:      fmt = FMT_NONE;
        endcase
    end

    // Immediate assembly. instr[31] is the sign bit for every format.
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = {{(INSTR_WIDTH-12){instr[31]}}, instr[31:20]};
            FMT_S: imm = {{(INSTR_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{(INSTR_WIDTH-13){instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            // U immediates occupy the full upper 20 bits; the cast widens
            // (sign-extends) only when INSTR_WIDTH exceeds 32.
            FMT_U: imm = INSTR_WIDTH'($signed({instr[31:12], 12'b0}));
            FMT_J: imm = {{(INSTR_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Registered RV32I decode pipeline stage between fetch and register-read.
//   Each incoming instruction is decoded combinationally (register names,
//   funct3, funct7[5], opcode, immediate, illegal flag) before it is stored,
//   so the holding registers always contain a finished bundle.
//
//   Storage is a main register (drives the outputs) plus a skid register,
//   which lets in_ready be a flop while still sustaining one transfer per
//   cycle.
//
//   Ports:
//     clk        in   1              rising-edge clock
//     reset      in   1              asynchronous active-high reset
//     flush      in   1              synchronous kill of held and incoming work
//     in_valid   in   1              upstream instruction valid
//     in_ready   out  1              stage can accept (registered)
//     in_instr   in   INSTR_WIDTH    raw instruction
//     in_pc      in   ADDR_WIDTH     PC of in_instr
//     out_valid  out  1              decoded bundle valid
//     out_ready  in   1              downstream accepts
//     pc         out  ADDR_WIDTH     PC of decoded instruction
//     op         out  OP_BITS        instr[6:0]
//     rs1/rs2/rd out  REG_NAME_BITS  register names, 0 when unused by format
//     funct3     out  FUNC_BITS      instr[14:12], 0 for U/J
//     funct7b5   out  1              instr[30] for OP/OP_IMM, else 0
//     imm        out  INSTR_WIDTH    sign-extended immediate, 0 for R
//     illegal    out  1              opcode outside RV32I
// -----------------------------------------------------------------------------
module decode_stage
    import riscv_pkg::*;
#(
    parameter int INSTR_WIDTH   = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int REG_NAME_BITS = 5,
    parameter int FUNC_BITS     = 3,
    parameter int OP_BITS       = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_WIDTH-1:0]   in_instr,
    input  logic [ADDR_WIDTH-1:0]    in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_WIDTH-1:0]    pc,
    output logic [OP_BITS-1:0]       op,
    output logic [REG_NAME_BITS-1:0] rs1,
    output logic [REG_NAME_BITS-1:0] rs2,
    output logic [REG_NAME_BITS-1:0] rd,
    output logic [FUNC_BITS-1:0]     funct3,
    output logic                     funct7b5,
    output logic [INSTR_WIDTH-1:0]   imm,
    output logic                     illegal
);

    // Fully decoded instruction as held in the main and skid registers.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]    pc;
        logic [OP_BITS-1:0]       op;
        logic [REG_NAME_BITS-1:0] rs1;
        logic [REG_NAME_BITS-1:0] rs2;
        logic [REG_NAME_BITS-1:0] rd;
        logic [FUNC_BITS-1:0]     funct3;
        logic                     funct7b5;
        logic [INSTR_WIDTH-1:0]   imm;
        logic                     illegal;
    } bundle_t;

    // Occupancy states of the main/skid pair.
    localparam logic [1:0] ST_EMPTY = 2'd0;  // nothing held
    localparam logic [1:0] ST_ONE   = 2'd1;  // main only
    localparam logic [1:0] ST_TWO   = 2'd2;  // main and skid

    // -------------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // -------------------------------------------------------------------------
    logic [INSTR_WIDTH-1:0] dec_imm;
    fmt_e                   dec_fmt;
    bundle_t                dec;

    imm_gen #(
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_imm_gen (
        .instr (in_instr),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    always_comb begin
        dec     = '0;
        dec.pc  = in_pc;
        dec.op  = in_instr[OP_BITS-1:0];
        if (dec_fmt == FMT_NONE) begin
            // Illegal instructions travel downstream carrying only op and pc
            // so the trap logic sees the offending address.
            dec.illegal = 1'b1;
        end else begin
            dec.imm = dec_imm;
            // U and J formats have no rs1 field (LUI/AUIPC/JAL).
            if ((dec_fmt != FMT_U) && (dec_fmt != FMT_J)) begin
                dec.rs1    = in_instr[15 +: REG_NAME_BITS];
                dec.funct3 = in_instr[12 +: FUNC_BITS];
            end
            // Only OP, STORE and BRANCH read a second source register.
            if ((dec_fmt == FMT_R) || (dec_fmt == FMT_S) || (dec_fmt == FMT_B)) begin
                dec.rs2 = in_instr[20 +: REG_NAME_BITS];
            end
            // STORE and BRANCH write no destination register.
            if ((dec_fmt != FMT_S) && (dec_fmt != FMT_B)) begin
                dec.rd = in_instr[7 +: REG_NAME_BITS];
            end
            if (has_funct7b5(in_instr[6:0])) begin
                dec.funct7b5 = in_instr[30];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Handshake and storage
    // -------------------------------------------------------------------------
    logic [1:0] state_reg;
    logic [1:0] state_next;
    bundle_t    main_reg;
    bundle_t    main_next;
    bundle_t    skid_reg;
    bundle_t    skid_next;
    logic       in_ready_reg;
    logic       accept;

    // in_ready_reg is already low in ST_TWO, so accept never fires there.
    assign accept = in_valid && in_ready_reg;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            // Flush wins over every transfer this cycle, including the
            // incoming instruction. Data registers are left as-is; they are
            // invisible while out_valid is low.
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        main_next  = dec;
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && out_ready) begin
                        // Downstream takes main while a new one replaces it.
                        main_next = dec;
                    end else if (accept) begin
                        skid_next  = dec;
                        state_next = ST_TWO;
                    end else if (out_ready) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_ready) begin
                        main_next  = skid_reg;
                        state_next = ST_ONE;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_EMPTY;
            main_reg     <= '0;
            skid_reg     <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            main_reg     <= main_next;
            skid_reg     <= skid_next;
            // Registered ready: low exactly when both entries will be full.
            in_ready_reg <= (state_next != ST_TWO);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg != ST_EMPTY);
    assign pc        = main_reg.pc;
    assign op        = main_reg.op;
    assign rs1       = main_reg.rs1;
    assign rs2       = main_reg.rs2;
    assign rd        = main_reg.rd;
    assign funct3    = main_reg.funct3;
    assign funct7b5  = main_reg.funct7b5;
    assign imm       = main_reg.imm;
    assign illegal   = main_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Self-checking bench for decode_stage. Stimulus is driven on the falling
//   edge, outputs are compared on the falling edge. A queue of decoded
//   bundles (capacity two) stands in for the stage's storage, and a decode
//   function derives every field directly from the RV32I field rules.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [31:0] imm;
        logic        illegal;
    } bundle_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
    logic        illegal;
    bundle_t     obs;

    int checks = 0;
    int errors = 0;
    bundle_t q[$];

    always #5 clk = ~clk;

    assign obs = '{pc: pc, op: op, rs1: rs1, rs2: rs2, rd: rd, funct3: funct3,
                   funct7b5: funct7b5, imm: imm, illegal: illegal};

    decode_stage dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc        (pc),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .imm       (imm),
        .illegal   (illegal)
    );

    // Reference decode, computed with arithmetic on the field values.
    function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] p);
        bundle_t     b;
        logic [6:0]  o;
        logic [31:0] v;
        bit is_r, is_i, is_s, is_b, is_u, is_j;
        o    = ins[6:0];
        is_r = (o == 7'h33);
        is_i = (o == 7'h13) || (o == 7'h03) || (o == 7'h67) || (o == 7'h0F) || (o == 7'h73);
        is_s = (o == 7'h23);
        is_b = (o == 7'h63);
        is_u = (o == 7'h37) || (o == 7'h17);
        is_j = (o == 7'h6F);
        b    = '0;
        b.pc = p;
        b.op = o;
        if (!(is_r || is_i || is_s || is_b || is_u || is_j)) begin
            b.illegal = 1'b1;
            return b;
        end
        v = 32'd0;
        if (is_i) v = 32'(ins[31:20]) - (ins[31] ? 32'd4096 : 32'd0);
        if (is_s) v = 32'({ins[31:25], ins[11:7]}) - (ins[31] ? 32'd4096 : 32'd0);
        if (is_b) v = 32'(ins[11:8]) * 2 + 32'(ins[30:25]) * 32 + 32'(ins[7]) * 2048
                      - (ins[31] ? 32'd4096 : 32'd0);
        if (is_u) v = ins & 32'hFFFF_F000;
        if (is_j) v = 32'(ins[30:21]) * 2 + 32'(ins[20]) * 2048 + 32'(ins[19:12]) * 4096
                      - (ins[31] ? 32'd1048576 : 32'd0);
        b.imm      = v;
        b.rs1      = (is_u || is_j) ? 5'd0 : ins[19:15];
        b.funct3   = (is_u || is_j) ? 3'd0 : ins[14:12];
        b.rs2      = (is_r || is_s || is_b) ? ins[24:20] : 5'd0;
        b.rd       = (is_s || is_b) ? 5'd0 : ins[11:7];
        b.funct7b5 = (o == 7'h33 || o == 7'h13) ? ins[30] : 1'b0;
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                  7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
        logic [31:0] ins;
        ins = $urandom();
        if ($urandom_range(9) != 0) ins[6:0] = ops[$urandom_range(10)];
        return ins;
    endfunction

    // One clock: drive inputs (called at a falling edge), advance the model
    // queue as the stage should, return at the next falling edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic ordy, input logic fl);
        int n;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = p;
        out_ready = ordy;
        flush     = fl;
        n = q.size();
        if (fl) begin
            q.delete();
        end else begin
            if (n > 0 && ordy) void'(q.pop_front());
            if (v && n < 2) q.push_back(model_decode(ins, p));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (obs !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", obs); end
        reset = 1'b0;
        q.delete();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_directed();
        cycle(1, 32'hFFF10093, 32'h100, 1, 0);   // addi x1,x2,-1
        checks++; if (out_valid !== 1'b1 || op !== 7'h13 || rs1 !== 5'd2 || rd !== 5'd1 || rs2 !== 5'd0 || imm !== 32'hFFFF_FFFF)
            begin errors++; $display("FAIL addi: got v=%b op=%h rs1=%0d rd=%0d rs2=%0d imm=%h expected v=1 op=13 rs1=2 rd=1 rs2=0 imm=ffffffff", out_valid, op, rs1, rd, rs2, imm); end
        $display("addi: op=%h rs1=%0d rd=%0d imm=%h", op, rs1, rd, imm);
        cycle(1, 32'h00512423, 32'h104, 1, 0);   // sw x5,8(x2)
        checks++; if (rs1 !== 5'd2 || rs2 !== 5'd5 || rd !== 5'd0 || funct3 !== 3'd2 || imm !== 32'd8)
            begin errors++; $display("FAIL sw: got rs1=%0d rs2=%0d rd=%0d f3=%0d imm=%h expected 2 5 0 2 00000008", rs1, rs2, rd, funct3, imm); end
        $display("sw: rs1=%0d rs2=%0d imm=%h", rs1, rs2, imm);
        cycle(1, 32'hFE000EE3, 32'h108, 1, 0);   // beq x0,x0,-4
        checks++; if (imm !== 32'hFFFF_FFFC || rd !== 5'd0)
            begin errors++; $display("FAIL beq: got imm=%h rd=%0d expected imm=fffffffc rd=0", imm, rd); end
        $display("beq: imm=%h", imm);
        cycle(1, 32'h123451B7, 32'h10C, 1, 0);   // lui x3,0x12345
        checks++; if (imm !== 32'h1234_5000 || rs1 !== 5'd0 || rd !== 5'd3 || pc !== 32'h10C)
            begin errors++; $display("FAIL lui: got imm=%h rs1=%0d rd=%0d pc=%h expected 12345000 0 3 0000010c", imm, rs1, rd, pc); end
        $display("lui: imm=%h rd=%0d", imm, rd);
        cycle(0, '0, '0, 1, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL directed_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ia, ib, ic;
        ia = rand_instr(); ib = rand_instr(); ic = rand_instr();
        cycle(1, ia, 32'h200, 0, 0);
        checks++; if (in_ready !== 1'b1 || obs !== model_decode(ia, 32'h200)) begin errors++; $display("FAIL bp_first: got r=%b %h expected r=1 %h", in_ready, obs, model_decode(ia, 32'h200)); end
        cycle(1, ib, 32'h204, 0, 0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
        checks++; if (obs !== model_decode(ia, 32'h200)) begin errors++; $display("FAIL bp_stable1: got %h expected %h", obs, model_decode(ia, 32'h200)); end
        cycle(1, ic, 32'h208, 0, 0);            // refused: stage is full
        checks++; if (out_valid !== 1'b1 || obs !== model_decode(ia, 32'h200)) begin errors++; $display("FAIL bp_stable2: got v=%b %h expected v=1 %h", out_valid, obs, model_decode(ia, 32'h200)); end
        cycle(0, '0, '0, 1, 0);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || obs !== model_decode(ib, 32'h204)) begin errors++; $display("FAIL bp_drain2: got v=%b r=%b %h expected v=1 r=1 %h", out_valid, in_ready, obs, model_decode(ib, 32'h204)); end
        cycle(0, '0, '0, 1, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
        $display("test_back_to_back done");
    endtask

    task automatic test_flush();
        cycle(1, rand_instr(), 32'h300, 0, 0);
        cycle(1, rand_instr(), 32'h304, 0, 0);
        cycle(1, rand_instr(), 32'h308, 0, 1);  // flush with TWO held and input valid
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush: got v=%b r=%b expected v=0 r=1", out_valid, in_ready); end
        cycle(0, '0, '0, 1, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_nothing_emitted: got %b expected 0", out_valid); end
        $display("test_flush done");
    endtask

    task automatic test_illegal();
        bundle_t e;
        cycle(1, 32'h0000_0000, 32'h400, 1, 0);
        e = '0; e.pc = 32'h400; e.illegal = 1'b1;
        checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || op !== 7'h00 || obs !== e) begin errors++; $display("FAIL illegal_zero: got v=%b %h expected v=1 %h", out_valid, obs, e); end
        cycle(1, 32'hFFF1_0090, 32'h404, 1, 0); // addi encoding with instr[1:0]=00
        e = '0; e.pc = 32'h404; e.op = 7'h10; e.illegal = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL illegal_lowbits: got %h expected %h", obs, e); end
        cycle(0, '0, '0, 1, 0);
        $display("test_illegal done");
    endtask

    task automatic test_random();
        int cyc_errs = 0;
        for (int i = 0; i < 2000; i++) begin
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; cyc_errs++; $display("FAIL rand_valid cyc %0d: got %b expected %b", i, out_valid, q.size() > 0); end
            checks++; if (in_ready !== (q.size() < 2)) begin errors++; cyc_errs++; $display("FAIL rand_ready cyc %0d: got %b expected %b", i, in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                checks++; if (obs !== q[0]) begin errors++; cyc_errs++; $display("FAIL rand_bundle cyc %0d: got %h expected %h", i, obs, q[0]); end
            end
            cycle($urandom_range(9) < 7, rand_instr(), $urandom(), $urandom_range(9) < 6, $urandom_range(39) == 0);
        end
        $display("test_random done: %0d mismatching cycles", cyc_errs);
    endtask

    task automatic test_reset_midstream();
        logic [31:0] ins;
        cycle(1, rand_instr(), 32'h500, 0, 0);
        cycle(1, rand_instr(), 32'h504, 0, 0);
        in_valid = 1'b0; flush = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin errors++; $display("FAIL reset_mid: got v=%b r=%b %h expected v=0 r=1 0", out_valid, in_ready, obs); end
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        ins = rand_instr();
        cycle(1, ins, 32'h600, 1, 0);
        checks++; if (out_valid !== 1'b1 || obs !== model_decode(ins, 32'h600)) begin errors++; $display("FAIL reset_recover: got v=%b %h expected v=1 %h", out_valid, obs, model_decode(ins, 32'h600)); end
        $display("test_reset_midstream done");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
